// File: rtl/arcade_inputs.sv
// Player-input front end: merges PS/2 keys, USB and UserIO pads into per-player control words,
// stretches coin pulses and shadows DIP/game-index bytes from ioctl. Define AUTOFIRE_EN to build autofire.
module arcade_inputs #(
    parameter int          PLAYERS      = 2,
    parameter int          DIP_BYTES    = 8,
    parameter logic [15:0] COIN_HOLD    = 16'd4800,
    parameter logic [15:0] AUTOFIRE_DIV = 16'd3200
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [10:0]            ps2_key,
    input  logic [PLAYERS*10-1:0]  joy_usb,
    input  logic [PLAYERS*10-1:0]  joy_ext,
    input  logic [2:0]             ext_count,
    input  logic [PLAYERS-1:0]     autofire_en,
    input  logic                   ioctl_wr,
    input  logic [7:0]             ioctl_index,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_data,
    output logic [PLAYERS*10-1:0]  player_out,
    output logic                   pause,
    output logic [DIP_BYTES*8-1:0] dip,
    output logic [3:0]             game_index
);

    logic                  old_tog_reg;
    logic                  tog_event;
    logic [9:0]            key0_reg;
    logic [9:0]            key0_next;
    logic [9:0]            key1_reg;
    logic [9:0]            key1_next;
    logic [2:0]            ext_lim;
    logic [PLAYERS*10-1:0] out_next;
    logic [PLAYERS-1:0]    pause_bits;
    logic [PLAYERS*10-1:0] player_out_reg;
    logic                  pause_reg;
    logic [3:0]            game_index_reg;

    // Every toggle change is one key event, so back-to-back events are applied in order.
    always_comb begin
        key0_next = key0_reg;
        key1_next = key1_reg;
        tog_event = (ps2_key[10] != old_tog_reg);
        if (tog_event) begin
            case (ps2_key[7:0])
                8'h74: key0_next[0] = ps2_key[9];
                8'h6B: key0_next[1] = ps2_key[9];
                8'h72: key0_next[2] = ps2_key[9];
                8'h75: key0_next[3] = ps2_key[9];
                8'h14: key0_next[4] = ps2_key[9];
                8'h11: key0_next[5] = ps2_key[9];
                8'h29: key0_next[6] = ps2_key[9];
                8'h16: key0_next[7] = ps2_key[9];
                8'h2E: key0_next[8] = ps2_key[9];
                8'h4D: key0_next[9] = ps2_key[9];
                8'h34: key1_next[0] = ps2_key[9];
                8'h23: key1_next[1] = ps2_key[9];
                8'h2B: key1_next[2] = ps2_key[9];
                8'h2D: key1_next[3] = ps2_key[9];
                8'h1C: key1_next[4] = ps2_key[9];
                8'h1B: key1_next[5] = ps2_key[9];
                8'h15: key1_next[6] = ps2_key[9];
                8'h1E: key1_next[7] = ps2_key[9];
                8'h36: key1_next[8] = ps2_key[9];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            old_tog_reg <= 1'b0;
            key0_reg    <= '0;
            key1_reg    <= '0;
        end else begin
            old_tog_reg <= ps2_key[10];
            key0_reg    <= key0_next;
            key1_reg    <= key1_next;
        end
    end

    assign ext_lim = (ext_count > 3'(PLAYERS)) ? 3'(PLAYERS) : ext_count;

`ifdef AUTOFIRE_EN
    logic [15:0] af_cnt_reg;
    logic        af_phase_reg;

    // Phase starts high so a fresh press is seen on the very next output edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            af_cnt_reg   <= '0;
            af_phase_reg <= 1'b1;
        end else if (af_cnt_reg >= AUTOFIRE_DIV - 16'd1) begin
            af_cnt_reg   <= '0;
            af_phase_reg <= ~af_phase_reg;
        end else begin
            af_cnt_reg   <= af_cnt_reg + 16'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = ps2_key[8];
`else
    logic unused_bits;
    assign unused_bits = ^{ps2_key[8], autofire_en, AUTOFIRE_DIV};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < PLAYERS; gi++) begin : g_player
            logic [9:0]  key_word;
            logic [9:0]  pad_word;
            logic [9:0]  raw_word;
            logic [9:0]  word_next;
            logic        coin_prev_reg;
            logic        coin_rise;
            logic [15:0] coin_cnt_reg;
            logic [15:0] coin_cnt_next;
            logic        b1_out;

            if (gi == 0) begin : g_key0
                assign key_word = key0_reg;
            end else if (gi == 1) begin : g_key1
                assign key_word = key1_reg;
            end else begin : g_nokey
                assign key_word = '0;
            end

            // UserIO pads take the lowest player slots, USB pads fill the rest in order.
            always_comb begin
                pad_word = joy_usb[gi*10 +: 10];
                if (int'(ext_lim) > gi) begin
                    pad_word = joy_ext[gi*10 +: 10];
                end else begin
                    for (int j = 0; j < PLAYERS; j++) begin
                        if (j + int'(ext_lim) == gi) begin
                            pad_word = joy_usb[j*10 +: 10];
                        end
                    end
                end
            end

            assign raw_word  = key_word | pad_word;
            assign coin_rise = raw_word[8] & ~coin_prev_reg;

            always_comb begin
                if (coin_rise) begin
                    coin_cnt_next = COIN_HOLD;
                end else if (coin_cnt_reg != 16'd0) begin
                    coin_cnt_next = coin_cnt_reg - 16'd1;
                end else begin
                    coin_cnt_next = 16'd0;
                end
            end

`ifdef AUTOFIRE_EN
            assign b1_out = autofire_en[gi] ? (raw_word[4] & af_phase_reg) : raw_word[4];
`else
            assign b1_out = raw_word[4];
`endif

            // Using the next count keeps a one-clock pulse high for exactly COIN_HOLD output clocks.
            assign word_next = {raw_word[9], raw_word[8] | (coin_cnt_next != 16'd0),
                                raw_word[7:5], b1_out, raw_word[3:0]};
            assign out_next[gi*10 +: 10] = word_next;
            assign pause_bits[gi]        = word_next[9];

            always_ff @(posedge clk) begin
                if (reset) begin
                    coin_prev_reg <= 1'b0;
                    coin_cnt_reg  <= '0;
                end else begin
                    coin_prev_reg <= raw_word[8];
                    coin_cnt_reg  <= coin_cnt_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            player_out_reg <= '0;
            pause_reg      <= 1'b0;
        end else begin
            player_out_reg <= out_next;
            pause_reg      <= |pause_bits;
        end
    end

    assign player_out = player_out_reg;
    assign pause      = pause_reg;

    // Loader state survives core resets; flops power up at 0 on the target fabric.
    always_ff @(posedge clk) begin
        if (ioctl_wr && ioctl_index == 8'd1) begin
            game_index_reg <= ioctl_data[3:0];
        end
    end
    assign game_index = game_index_reg;

    generate
        for (gi = 0; gi < DIP_BYTES; gi++) begin : g_dip
            logic [7:0] dip_byte_reg;

            always_ff @(posedge clk) begin
                if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr == 25'(gi)) begin
                    dip_byte_reg <= ioctl_data;
                end
            end
            assign dip[gi*8 +: 8] = dip_byte_reg;
        end
    endgenerate

endmodule

// File: tb/tb_arcade_inputs.sv
// Directed bench for arcade_inputs: pad-select vector table plus keyboard, coin, ioctl,
// reset and autofire sequences.
module tb_arcade_inputs;

    localparam int P = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [10:0]   ps2_key;
    logic [P*10-1:0] joy_usb;
    logic [P*10-1:0] joy_ext;
    logic [2:0]    ext_count;
    logic [P-1:0]  autofire_en;
    logic          ioctl_wr;
    logic [7:0]    ioctl_index;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_data;
    logic [P*10-1:0] player_out;
    logic          pause;
    logic [63:0]   dip;
    logic [3:0]    game_index;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arcade_inputs #(
        .PLAYERS      (P),
        .DIP_BYTES    (8),
        .COIN_HOLD    (16'd8),
        .AUTOFIRE_DIV (16'd4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_key     (ps2_key),
        .joy_usb     (joy_usb),
        .joy_ext     (joy_ext),
        .ext_count   (ext_count),
        .autofire_en (autofire_en),
        .ioctl_wr    (ioctl_wr),
        .ioctl_index (ioctl_index),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .player_out  (player_out),
        .pause       (pause),
        .dip         (dip),
        .game_index  (game_index)
    );

    typedef struct {
        logic [2:0]  ec;
        logic [19:0] usb;
        logic [19:0] ext;
        logic [19:0] exp_out;
        logic        exp_pause;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ioctl_write(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_data  = data;
        tick();
        ioctl_wr    = 1'b0;
    endtask

    task automatic coin_run(input int second, output logic [19:0] tr);
        ext_count = 3'd0;
        for (int k = 0; k < 20; k++) begin
            joy_usb = (k == 0 || k == second) ? 20'h40000 : 20'h0;
            tick();
            tr[k] = player_out[18];
        end
        joy_usb = '0;
    endtask

    initial begin
        logic [19:0] tr;
        logic [15:0] af_tr;
        logic [7:0]  hold_tr;

        vecs[0] = '{ec: 3'd1, usb: 20'h3C004, ext: 20'h00001, exp_out: 20'h01001, exp_pause: 1'b0};
        vecs[1] = '{ec: 3'd0, usb: 20'h3C004, ext: 20'h00001, exp_out: 20'h3C004, exp_pause: 1'b0};
        vecs[2] = '{ec: 3'd2, usb: 20'h3FCFF, ext: 20'h0C00A, exp_out: 20'h0C00A, exp_pause: 1'b0};
        vecs[3] = '{ec: 3'd7, usb: 20'h3FCFF, ext: 20'h0C00A, exp_out: 20'h0C00A, exp_pause: 1'b0};
        vecs[4] = '{ec: 3'd0, usb: 20'h00200, ext: 20'h00000, exp_out: 20'h00200, exp_pause: 1'b1};
        vecs[5] = '{ec: 3'd1, usb: 20'h002A0, ext: 20'h00000, exp_out: 20'hA8000, exp_pause: 1'b1};
        vecs[6] = '{ec: 3'd2, usb: 20'h00200, ext: 20'h00000, exp_out: 20'h00000, exp_pause: 1'b0};
        vecs[7] = '{ec: 3'd3, usb: 20'h00000, ext: 20'h04040, exp_out: 20'h04040, exp_pause: 1'b0};

        reset       = 1'b1;
        ps2_key     = '0;
        joy_usb     = 20'h3C204;
        joy_ext     = 20'h00001;
        ext_count   = 3'd1;
        autofire_en = '0;
        ioctl_wr    = 1'b0;
        ioctl_index = '0;
        ioctl_addr  = '0;
        ioctl_data  = '0;
        @(negedge clk);
        tick();
        tick();
        check("reset_out", player_out, 20'h0);
        check("reset_pause", pause, 1'b0);
        reset   = 1'b0;
        joy_usb = '0;
        joy_ext = '0;
        tick();

        for (int i = 0; i < 8; i++) begin
            ext_count = vecs[i].ec;
            joy_usb   = vecs[i].usb;
            joy_ext   = vecs[i].ext;
            tick();
            check($sformatf("vec%0d_out", i), player_out, vecs[i].exp_out);
            check($sformatf("vec%0d_pause", i), pause, vecs[i].exp_pause);
        end
        joy_usb = '0;
        joy_ext = '0;
        ext_count = 3'd0;
        tick();

        // Keyboard: press then release U on player 0.
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
        tick();
        check("kbd_up_lat1", player_out[3], 1'b0);
        tick();
        check("kbd_up_press", player_out[3], 1'b1);
        check("kbd_p1_up_clear", player_out[13], 1'b0);
        ps2_key = {1'b0, 1'b0, 1'b0, 8'h75};
        tick();
        check("kbd_up_hold", player_out[3], 1'b1);
        tick();
        check("kbd_up_release", player_out[3], 1'b0);
        check("kbd_p1_up_clear2", player_out[13], 1'b0);

        // Back-to-back events: L press, p1 B1 press, L release.
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h6B};
        tick();
        ps2_key = {1'b0, 1'b1, 1'b0, 8'h1C};
        tick();
        ps2_key = {1'b1, 1'b0, 1'b0, 8'h6B};
        tick();
        check("kbd_burst_mid", player_out, 20'h04002);
        tick();
        check("kbd_burst_end", player_out, 20'h04000);
        ps2_key = {1'b0, 1'b1, 1'b0, 8'h99};
        tick();
        tick();
        check("kbd_unmapped", player_out, 20'h04000);
        ps2_key = {1'b1, 1'b0, 1'b0, 8'h1C};
        tick();
        tick();
        check("kbd_b1_release", player_out, 20'h00000);
        ps2_key = {1'b0, 1'b1, 1'b0, 8'h4D};
        tick();
        tick();
        check("kbd_pause_out", player_out, 20'h00200);
        check("kbd_pause", pause, 1'b1);
        ps2_key = {1'b1, 1'b0, 1'b0, 8'h4D};
        tick();
        tick();
        check("kbd_pause_off", pause, 1'b0);

        // Coin stretch on player 1.
        coin_run(-1, tr);
        check("coin_single", tr, 20'h000FF);
        coin_run(5, tr);
        check("coin_retrigger", tr, 20'h01FFF);

        // ioctl DIP and game index capture.
        ioctl_write(8'd254, 25'd0, 8'hA5);
        ioctl_write(8'd254, 25'd7, 8'h3C);
        tick();
        check("dip_byte0", dip[7:0], 8'hA5);
        check("dip_byte7", dip[63:56], 8'h3C);
        ioctl_write(8'd254, 25'd8, 8'hFF);
        ioctl_write(8'd253, 25'd1, 8'h77);
        tick();
        check("dip_addr8_ignored", dip, 64'h3C000000000000A5);
        ioctl_write(8'd1, 25'd0, 8'h37);
        tick();
        check("game_index", game_index, 4'h7);
        reset = 1'b1;
        ioctl_write(8'd1, 25'd0, 8'h0C);
        tick();
        check("dip_keep_in_reset", dip, 64'h3C000000000000A5);
        check("game_index_in_reset", game_index, 4'hC);
        reset = 1'b0;
        tick();

        // Reset with a key held and the coin counter running.
        ps2_key   = {1'b0, 1'b1, 1'b0, 8'h75};
        ext_count = 3'd0;
        joy_usb   = 20'h00100;
        tick();
        joy_usb = '0;
        tick();
        tick();
        check("pre_reset_out", player_out, 20'h00108);
        reset   = 1'b1;
        ps2_key = '0;
        tick();
        check("mid_reset_out", player_out, 20'h0);
        check("mid_reset_pause", pause, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("post_reset_out", player_out, 20'h0);

        // Autofire on player 0 B1, aligned to reset release.
        reset       = 1'b1;
        ext_count   = 3'd0;
        joy_usb     = 20'h00010;
        autofire_en = 2'b01;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            tick();
            af_tr[k] = player_out[4];
        end
`ifdef AUTOFIRE_EN
        check("autofire_pattern", af_tr, 16'h0F0F);
`else
        check("autofire_bypass", af_tr, 16'hFFFF);
`endif
        autofire_en = 2'b00;
        for (int k = 0; k < 8; k++) begin
            tick();
            hold_tr[k] = player_out[4];
        end
        check("autofire_off_hold", hold_tr, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
